uart_xcvr: RTL and testbench

UART_XCVR -- requirements
Module: uart_xcvr

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 53 +++++
 rtl/uart_xcvr.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_xcvr.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM state types and the default oversampling
// factor.
package uart_pkg;

    localparam logic [1:0] ParityNone = 2'b00;
    localparam logic [1:0] ParityEven = 2'b01;
    localparam logic [1:0] ParityOdd  = 2'b10;

    localparam int unsigned DefaultOvs = 16;

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. The read data reads as zero
// while the FIFO is empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             empty, do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so push-while-full is accepted only with a pop.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (!do_push && do_pop) level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver: shared baud tick generator, TX and RX framing FSMs, and a FIFO per
// direction. Frames carry DATA_BITS data bits, optional parity and one or two stop bits.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVS        = DefaultOvs
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [7:0]                    tx_wdata,
    input  logic                          tx_wr,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic                          tx,
    input  logic                          rx,
    input  logic                          rx_rd,
    output logic [7:0]                    rx_rdata,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err,
    input  logic                          err_clr
);

    localparam int unsigned CntW = $clog2(2 * OVS);
    localparam int unsigned BitW = $clog2(DATA_BITS);
    localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0] baud_cnt_q, baud_div_q;
    logic        tick;

    // The divider is resampled only on wrap so a change never truncates a running period.
    assign tick = (baud_cnt_q == baud_div_q);

    always_ff @(posedge clk) begin
        if (!reset || tick) begin
            baud_cnt_q <= '0;
            baud_div_q <= baud_div;
        end else begin
            baud_cnt_q <= baud_cnt_q + 16'd1;
        end
    end

    logic [DATA_BITS-1:0] txf_rdata, rxf_rdata;
    logic [LvlW-1:0]      txf_level;
    logic                 txf_pop, rxf_push, rxf_full;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .wdata_i (tx_wdata[DATA_BITS-1:0]),
        .push_i  (tx_wr),
        .pop_i   (txf_pop),
        .rdata_o (txf_rdata),
        .full_o  (tx_full),
        .level_o (txf_level)
    );

    tx_state_e            tx_state_q, tx_state_d;
    logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
    logic                 tx_two_q, tx_two_d, tx_q, tx_d, tx_load;

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != TxIdle) || (txf_level != '0);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_two_d     = tx_two_q;
        tx_load      = 1'b0;
        unique case (tx_state_q)
            TxIdle: tx_load = tick && (txf_level != '0);
            TxStart: if (tick) begin
                if (tx_cnt_q == CntW'(OVS - 1)) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            TxData: if (tick) begin
                if (tx_cnt_q == CntW'(OVS - 1)) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == BitW'(DATA_BITS - 1)) begin
                        tx_state_d = tx_par_en_q ? TxParity : TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            TxParity: if (tick) begin
                if (tx_cnt_q == CntW'(OVS - 1)) begin
                    tx_state_d = TxStop;
                    tx_cnt_d   = '0;
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            TxStop: if (tick) begin
                if (tx_cnt_q == (tx_two_q ? CntW'(2 * OVS - 1) : CntW'(OVS - 1))) begin
                    tx_state_d = TxIdle;
                    tx_load    = (txf_level != '0);
                end else tx_cnt_d = tx_cnt_q + 1'b1;
            end
            default: tx_state_d = TxIdle;
        endcase
        // Loading straight from STOP gives back-to-back frames with no idle bit between.
        if (tx_load) begin
            tx_state_d   = TxStart;
            tx_cnt_d     = '0;
            tx_shift_d   = txf_rdata;
            tx_par_en_d  = (parity_mode == ParityEven) || (parity_mode == ParityOdd);
            tx_par_bit_d = (^txf_rdata) ^ (parity_mode == ParityOdd);
            tx_two_d     = two_stop;
        end
        txf_pop = tx_load;
        unique case (tx_state_d)
            TxStart:  tx_d = 1'b0;
            TxData:   tx_d = tx_shift_d[0];
            TxParity: tx_d = tx_par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q   <= TxIdle;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_two_q     <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_two_q     <= tx_two_d;
            tx_q         <= tx_d;
        end
    end

    rx_state_e            rx_state_q, rx_state_d;
    logic [1:0]           rx_sync_q;
    logic [CntW-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_par_q, rx_par_d;
    logic                 rx_s, par_set, frame_set, ovr_set;
    logic                 par_err_q, frame_err_q, ovr_err_q;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_par_d    = rx_par_q;
        rxf_push    = 1'b0;
        par_set     = 1'b0;
        frame_set   = 1'b0;
        unique case (rx_state_q)
            RxIdle: if (!rx_s) begin
                rx_state_d  = RxStart;
                rx_cnt_d    = '0;
                rx_par_en_d = (parity_mode == ParityEven) || (parity_mode == ParityOdd);
                rx_odd_d    = (parity_mode == ParityOdd);
            end
            // Mid-start-bit recheck filters glitches; later samples land one bit apart.
            RxStart: if (tick) begin
                if (rx_cnt_q == CntW'(OVS / 2 - 1)) begin
                    rx_state_d = rx_s ? RxIdle : RxData;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            RxData: if (tick) begin
                if (rx_cnt_q == CntW'(OVS - 1)) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BitW'(DATA_BITS - 1)) begin
                        rx_state_d = rx_par_en_q ? RxParity : RxStop;
                    end else rx_bit_d = rx_bit_q + 1'b1;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            RxParity: if (tick) begin
                if (rx_cnt_q == CntW'(OVS - 1)) begin
                    rx_state_d = RxStop;
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s;
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            RxStop: if (tick) begin
                if (rx_cnt_q == CntW'(OVS - 1)) begin
                    rx_state_d = RxIdle;
                    rxf_push   = rx_s;
                    frame_set  = !rx_s;
                    par_set    = rx_s && rx_par_en_q && (rx_par_q != ((^rx_shift_q) ^ rx_odd_q));
                end else rx_cnt_d = rx_cnt_q + 1'b1;
            end
            default: rx_state_d = RxIdle;
        endcase
        ovr_set = rxf_push && rxf_full && !rx_rd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sync_q   <= 2'b11;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_par_q    <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            rx_sync_q   <= {rx_sync_q[0], rx};
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_par_q    <= rx_par_d;
            par_err_q   <= par_set | (par_err_q & ~err_clr);
            frame_err_q <= frame_set | (frame_err_q & ~err_clr);
            ovr_err_q   <= ovr_set | (ovr_err_q & ~err_clr);
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .wdata_i (rx_shift_q),
        .push_i  (rxf_push),
        .pop_i   (rx_rd),
        .rdata_o (rxf_rdata),
        .full_o  (rxf_full),
        .level_o (rx_level)
    );

    assign rx_empty    = (rx_level == '0);
    assign rx_rdata    = 8'(rxf_rdata);
    assign parity_err  = par_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = ovr_err_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr: TX waveform, loopback, RX error cases, overrun and
// mid-frame reset, with received words checked against a scoreboard queue.
module tb_uart_xcvr;

    logic        clk = 1'b0;
    logic        reset, two_stop, tx_wr, tx_full, tx_busy, tx, rx, rx_rd, rx_empty;
    logic        parity_err, frame_err, overrun_err, err_clr, loop_en, rx_drv;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic [7:0]  tx_wdata, rx_rdata;
    logic [2:0]  rx_level;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;
    assign rx = loop_en ? tx : rx_drv;

    uart_xcvr #(.DATA_BITS(8), .FIFO_DEPTH(4), .OVS(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx_wdata    (tx_wdata),
        .tx_wr       (tx_wr),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .tx          (tx),
        .rx          (rx),
        .rx_rd       (rx_rd),
        .rx_rdata    (rx_rdata),
        .rx_empty    (rx_empty),
        .rx_level    (rx_level),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_wdata = d;
        tx_wr    = 1'b1;
        @(negedge clk);
        tx_wr    = 1'b0;
    endtask

    task automatic read_expect(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        check_eq(tag, {23'd0, rx_empty, rx_rdata}, {23'd0, 1'b0, e});
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_level(input int lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(rx_level) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, rx_level, lvl);
    endtask

    // Drives one 8-bit frame on rx at 16 cycles per bit (baud_div = 0).
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input bit bad_par,
                              input bit stop_ok);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (16) @(negedge clk);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            rx_drv = (^d) ^ (pm == 2'b10) ^ bad_par;
            repeat (16) @(negedge clk);
        end
        if (stop_ok) begin
            rx_drv = 1'b1;
            repeat (16) @(negedge clk);
        end else begin
            rx_drv = 1'b0;
            repeat (12) @(negedge clk);
            rx_drv = 1'b1;
        end
        repeat (32) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt;
        logic [7:0] byte_a5;
        byte_a5     = 8'hA5;
        reset       = 1'b0;
        baud_div    = 16'd0;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        tx_wdata    = 8'h00;
        tx_wr       = 1'b0;
        rx_rd       = 1'b0;
        err_clr     = 1'b0;
        loop_en     = 1'b0;
        rx_drv      = 1'b1;
        repeat (3) @(negedge clk);

        check_eq("rst_tx", tx, 1);
        check_eq("rst_tx_busy", tx_busy, 0);
        check_eq("rst_tx_full", tx_full, 0);
        check_eq("rst_rx_empty", rx_empty, 1);
        check_eq("rst_rx_level", rx_level, 0);
        check_eq("rst_rx_rdata", rx_rdata, 0);
        check_eq("rst_flags", {parity_err, frame_err, overrun_err}, 0);
        reset = 1'b1;
        @(negedge clk);

        // 8N1 frame of 0xA5 on tx
        tx_write(8'hA5);
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_start_seen", tx, 0);
        cnt = 0;
        while (tx === 1'b0 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("tx_start_len", cnt, 16);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("tx_bit%0d", i), tx, byte_a5[i]);
            repeat (16) @(negedge clk);
        end
        check_eq("tx_stop", tx, 1);
        check_eq("tx_busy_in_stop", tx_busy, 1);
        n = 0;
        while (tx_busy && n < 24) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_busy_fall", tx_busy, 0);
        check_eq("tx_idle_high", tx, 1);

        // 8E2 loopback
        loop_en     = 1'b1;
        parity_mode = 2'b01;
        two_stop    = 1'b1;
        @(negedge clk);
        tx_write(8'h00); exp_q.push_back(8'h00);
        tx_write(8'hFF); exp_q.push_back(8'hFF);
        tx_write(8'h3C); exp_q.push_back(8'h3C);
        wait_level(3, 900, "lb_level");
        repeat (40) @(negedge clk);
        check_eq("lb_flags", {parity_err, frame_err, overrun_err}, 0);
        read_expect("lb_word0");
        read_expect("lb_word1");
        read_expect("lb_word2");
        check_eq("lb_empty", rx_empty, 1);
        loop_en  = 1'b0;
        two_stop = 1'b0;

        // Wrong parity bit: flagged but kept
        send_frame(8'h5A, 2'b01, 1'b1, 1'b1);
        exp_q.push_back(8'h5A);
        check_eq("par_err_set", parity_err, 1);
        check_eq("par_frame_clean", frame_err, 0);
        check_eq("par_level", rx_level, 1);
        read_expect("par_word");
        pulse_clr();
        check_eq("par_err_clr", parity_err, 0);

        // Low stop bit: flagged and dropped
        send_frame(8'h33, 2'b01, 1'b0, 1'b0);
        check_eq("frm_err_set", frame_err, 1);
        check_eq("frm_level", rx_level, 0);
        pulse_clr();
        check_eq("frm_err_clr", frame_err, 0);

        // Short glitch rejected by the start-bit recheck
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("glitch_level", rx_level, 0);
        check_eq("glitch_flags", {parity_err, frame_err, overrun_err}, 0);

        // Overrun on the fifth unread frame
        parity_mode = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i * 17), 2'b00, 1'b0, 1'b1);
            if (i <= 4) exp_q.push_back(8'(i * 17));
        end
        check_eq("ovr_level", rx_level, 4);
        check_eq("ovr_err_set", overrun_err, 1);
        for (int i = 0; i < 4; i++) read_expect($sformatf("ovr_word%0d", i));
        check_eq("ovr_empty", rx_empty, 1);
        pulse_clr();
        check_eq("ovr_err_clr", overrun_err, 0);
        check_eq("sb_drained", exp_q.size(), 0);

        // Reset during the data bits of the second of three queued frames
        tx_write(8'h81);
        tx_write(8'h42);
        tx_write(8'h24);
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("rtx_first_start", tx, 0);
        repeat (190) @(negedge clk);
        check_eq("rtx_busy_before", tx_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rtx_tx_high", tx, 1);
        check_eq("rtx_busy_low", tx_busy, 0);
        check_eq("rtx_full_low", tx_full, 0);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt++;
        end
        check_eq("rtx_no_more_frames", cnt, 0);
        check_eq("rtx_busy_after", tx_busy, 0);

        // Reset in the middle of a received frame
        rx_drv = 1'b0;
        repeat (40) @(negedge clk);
        reset  = 1'b0;
        rx_drv = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("rrx_level", rx_level, 0);
        check_eq("rrx_empty", rx_empty, 1);
        check_eq("rrx_flags", {parity_err, frame_err, overrun_err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
